// File: rtl/rotary_decoder.sv
// Quadrature decoder for a debounced rotary encoder: Gray-code A/B tracking,
// sub-detent accumulation, position counting and push-button edge detection.
module rotary_decoder #(
    parameter int CNT_W            = 8,
    parameter int CNT_MAX          = 255,
    parameter int EDGES_PER_DETENT = 4,
    parameter int WRAP             = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             rotAreg,
    input  logic             rotBreg,
    input  logic             rotCTRreg,
    input  logic             en,
    input  logic             clr,
    output logic [CNT_W-1:0] position,
    output logic             step,
    output logic             dir,
    output logic             press,
    output logic             err
);

    localparam logic [CNT_W-1:0]  POS_MAX = CNT_W'(CNT_MAX);
    localparam logic signed [3:0] Q_MAX   = 4'(EDGES_PER_DETENT - 1);
    localparam logic signed [3:0] Q_MIN   = -Q_MAX;

    logic [1:0]        cur_ab;
    logic [1:0]        prev_ab;
    logic              loaded;
    logic              valid;
    logic              pressed_d;
    logic signed [3:0] q;

    logic              fwd;
    logic              rev;
    logic              illegal;
    logic [1:0]        delta;
    logic [CNT_W-1:0]  pos_inc;
    logic [CNT_W-1:0]  pos_dec;

    logic signed [3:0] q_next;
    logic [CNT_W-1:0]  position_next;
    logic              step_next;
    logic              dir_next;

    // Map the Gray code onto a 0..3 phase so a transition is a modular difference.
    function automatic logic [1:0] phase(input logic [1:0] ab);
        case (ab)
            2'b00:   phase = 2'd0;
            2'b01:   phase = 2'd1;
            2'b11:   phase = 2'd2;
            default: phase = 2'd3;
        endcase
    endfunction

    always_comb begin
        delta   = phase(cur_ab) - phase(prev_ab);
        fwd     = valid && (delta == 2'd1);
        rev     = valid && (delta == 2'd3);
        illegal = valid && (delta == 2'd2);
    end

    always_comb begin
        pos_inc = position + 1'b1;
        if (position >= POS_MAX) begin
            pos_inc = (WRAP != 0) ? '0 : POS_MAX;
        end
        pos_dec = position - 1'b1;
        if (position == '0) begin
            pos_dec = (WRAP != 0) ? POS_MAX : '0;
        end
    end

    always_comb begin
        q_next        = q;
        position_next = position;
        step_next     = 1'b0;
        dir_next      = dir;
        if (en) begin
            if (illegal) begin
                q_next = '0;
            end else if (fwd) begin
                if (q == Q_MAX) begin
                    q_next        = '0;
                    step_next     = 1'b1;
                    dir_next      = 1'b1;
                    position_next = pos_inc;
                end else begin
                    q_next = q + 4'sd1;
                end
            end else if (rev) begin
                if (q == Q_MIN) begin
                    q_next        = '0;
                    step_next     = 1'b1;
                    dir_next      = 1'b0;
                    position_next = pos_dec;
                end else begin
                    q_next = q - 4'sd1;
                end
            end
        end
        // Clear wins over a detent completing on the same edge; direction is kept.
        if (clr) begin
            q_next        = '0;
            position_next = '0;
            step_next     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_ab    <= 2'b00;
            prev_ab   <= 2'b00;
            loaded    <= 1'b0;
            valid     <= 1'b0;
            pressed_d <= 1'b0;
            q         <= '0;
            position  <= '0;
            step      <= 1'b0;
            dir       <= 1'b0;
            press     <= 1'b0;
            err       <= 1'b0;
        end else begin
            cur_ab    <= {rotAreg, rotBreg};
            prev_ab   <= cur_ab;
            loaded    <= 1'b1;
            valid     <= loaded;
            pressed_d <= rotCTRreg;
            q         <= q_next;
            position  <= position_next;
            step      <= step_next;
            dir       <= dir_next;
            press     <= rotCTRreg & ~pressed_d;
            err       <= illegal;
        end
    end

endmodule

// File: tb/tb_rotary_decoder.sv
// Directed bench for rotary_decoder: a wrapping and a saturating instance share stimulus.
module tb_rotary_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       rot_a, rot_b, rot_ctr;
    logic       en, clr;

    logic [7:0] position1, position2;
    logic       step1, dir1, press1, err1;
    logic       step2, dir2, press2, err2;

    int checks = 0;
    int errors = 0;
    int step1_cnt = 0, step2_cnt = 0, err1_cnt = 0, press1_cnt = 0;
    int base_s1, base_s2, base_e1, base_p1;

    always #5 clk = ~clk;

    rotary_decoder #(.CNT_W(8), .CNT_MAX(255), .EDGES_PER_DETENT(4), .WRAP(1)) dut_wrap (
        .clk(clk), .reset(reset), .rotAreg(rot_a), .rotBreg(rot_b), .rotCTRreg(rot_ctr),
        .en(en), .clr(clr), .position(position1), .step(step1), .dir(dir1),
        .press(press1), .err(err1)
    );

    rotary_decoder #(.CNT_W(8), .CNT_MAX(255), .EDGES_PER_DETENT(4), .WRAP(0)) dut_sat (
        .clk(clk), .reset(reset), .rotAreg(rot_a), .rotBreg(rot_b), .rotCTRreg(rot_ctr),
        .en(en), .clr(clr), .position(position2), .step(step2), .dir(dir2),
        .press(press2), .err(err2)
    );

    // Pulse counters: a pulse held for two cycles counts twice.
    always @(negedge clk) begin
        if (step1)  step1_cnt  <= step1_cnt + 1;
        if (step2)  step2_cnt  <= step2_cnt + 1;
        if (err1)   err1_cnt   <= err1_cnt + 1;
        if (press1) press1_cnt <= press1_cnt + 1;
    end

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [1:0] v);
        {rot_a, rot_b} = v;
        tick(3);
    endtask

    task automatic snap();
        base_s1 = step1_cnt;
        base_s2 = step2_cnt;
        base_e1 = err1_cnt;
        base_p1 = press1_cnt;
    endtask

    task automatic cw_detent();
        drive(2'b01); drive(2'b11); drive(2'b10); drive(2'b00);
    endtask

    initial begin
        reset = 1'b1; rot_a = 1'b0; rot_b = 1'b0; rot_ctr = 1'b0; en = 1'b1; clr = 1'b0;
        tick(3);
        check("reset_pos", int'(position1), 0);
        check("reset_step", int'(step1), 0);
        check("reset_dir", int'(dir1), 0);
        check("reset_press", int'(press1), 0);
        check("reset_err", int'(err1), 0);
        reset = 1'b0;
        tick(3);

        // One clockwise detent.
        snap();
        cw_detent();
        check("cw_steps", step1_cnt - base_s1, 1);
        check("cw_dir", int'(dir1), 1);
        check("cw_pos", int'(position1), 1);

        // Clear, then one counter-clockwise detent wraps to the top.
        clr = 1'b1; tick(1); clr = 1'b0; tick(1);
        check("clr_pos", int'(position1), 0);
        snap();
        drive(2'b10); drive(2'b11); drive(2'b01); drive(2'b00);
        check("ccw_steps", step1_cnt - base_s1, 1);
        check("ccw_dir", int'(dir1), 0);
        check("ccw_wrap_pos", int'(position1), 255);

        // Mid-detent reversal: no step, no error.
        snap();
        drive(2'b01); drive(2'b11); drive(2'b01); drive(2'b00);
        check("rev_steps", step1_cnt - base_s1, 0);
        check("rev_errs", err1_cnt - base_e1, 0);
        check("rev_pos", int'(position1), 255);
        snap();
        cw_detent();
        check("rev_then_cw_steps", step1_cnt - base_s1, 1);
        check("cw_wrap_pos", int'(position1), 0);

        // Illegal jump clears the accumulator.
        snap();
        drive(2'b11);
        check("illegal_err_pulses", err1_cnt - base_e1, 1);
        drive(2'b10); drive(2'b00); drive(2'b01);
        check("after_err_3cw_steps", step1_cnt - base_s1, 0);
        drive(2'b11);
        check("after_err_4cw_steps", step1_cnt - base_s1, 1);
        check("after_err_pos", int'(position1), 1);

        // Clear coincident with the decode of the completing transition.
        snap();
        drive(2'b10); drive(2'b00); drive(2'b01);
        {rot_a, rot_b} = 2'b11;
        tick(1);
        clr = 1'b1; tick(1); clr = 1'b0;
        tick(2);
        check("clr_coincident_steps", step1_cnt - base_s1, 0);
        check("clr_coincident_pos", int'(position1), 0);
        check("clr_keeps_dir", int'(dir1), 1);

        // Reset after two transitions discards them.
        drive(2'b10); drive(2'b00);
        reset = 1'b1; tick(1);
        check("midreset_pos", int'(position1), 0);
        check("midreset_dir", int'(dir1), 0);
        check("midreset_step", int'(step1), 0);
        reset = 1'b0; tick(3);
        snap();
        drive(2'b01); drive(2'b11);
        check("postreset_2cw_steps", step1_cnt - base_s1, 0);
        drive(2'b10); drive(2'b00);
        check("postreset_4cw_steps", step1_cnt - base_s1, 1);
        check("postreset_pos", int'(position1), 1);

        // Held button gives one press pulse; release gives none.
        snap();
        rot_ctr = 1'b1; tick(10);
        rot_ctr = 1'b0; tick(4);
        check("press_pulses", press1_cnt - base_p1, 1);

        // Disabled: no steps, position frozen, errors still reported.
        snap();
        en = 1'b0;
        cw_detent();
        drive(2'b11); drive(2'b10); drive(2'b00);
        en = 1'b1;
        tick(1);
        check("en0_steps", step1_cnt - base_s1, 0);
        check("en0_pos", int'(position1), 1);
        check("en0_err", err1_cnt - base_e1, 1);

        // Saturating instance at the lower bound.
        clr = 1'b1; tick(1); clr = 1'b0; tick(1);
        snap();
        drive(2'b10); drive(2'b11); drive(2'b01); drive(2'b00);
        check("sat_low_pos", int'(position2), 0);
        check("sat_low_steps", step2_cnt - base_s2, 1);
        check("sat_low_dir", int'(dir2), 0);
        check("wrap_low_pos", int'(position1), 255);

        // Walk to the top, then one more detent.
        clr = 1'b1; tick(1); clr = 1'b0; tick(1);
        for (int i = 0; i < 255; i++) cw_detent();
        check("sat_top_pos", int'(position2), 255);
        check("wrap_top_pos", int'(position1), 255);
        snap();
        cw_detent();
        check("sat_hold_pos", int'(position2), 255);
        check("sat_hold_steps", step2_cnt - base_s2, 1);
        check("sat_hold_dir", int'(dir2), 1);
        check("wrap_over_pos", int'(position1), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
